// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : multi-port GPR file, two prioritised writes, bypass, busy scoreboard
// Revision : 1.0
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int c_depth = 2**ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_depth];
  logic [c_depth-1:0] r_busy;
  logic [c_depth-1:0] w_busy_nxt;
  logic               w_wen0;
  logic               w_wen1;

  always_comb begin
    w_wen0 = we0 && ((ZERO_REG == 0) || (wa0 != '0));
    w_wen1 = we1 && ((ZERO_REG == 0) || (wa1 != '0));
  end

  // Alloc is applied after the clears so a new producer supersedes a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we0)      w_busy_nxt[wa0]        = 1'b0;
    if (we1)      w_busy_nxt[wa1]        = 1'b0;
    if (alloc_en) w_busy_nxt[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < c_depth; n++) r_mem[n] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wen0) r_mem[wa0] <= wd0;
      if (w_wen1) r_mem[wa1] <= wd1;
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    logic              w_b;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_alloc_hit;

    assign w_a = rd_addr[i*ADDR_W +: ADDR_W];

    // Forwarding is gated by rst_n so the read ports stay at zero during reset.
    always_comb begin
      w_hit0      = rst_n && we0 && (wa0 == w_a);
      w_hit1      = rst_n && we1 && (wa1 == w_a);
      w_alloc_hit = alloc_en && (alloc_addr == w_a);
      w_d         = r_mem[w_a];
      w_b         = r_busy[w_a];
      if (BYPASS != 0) begin
        if (w_hit1)      w_d = wd1;
        else if (w_hit0) w_d = wd0;
        if ((w_hit0 || w_hit1) && !w_alloc_hit) w_b = 1'b0;
      end
      if ((ZERO_REG != 0) && (w_a == '0)) begin
        w_d = '0;
        w_b = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = w_d;
    assign rd_busy[i]                  = w_b;
  end

  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : r_mem[dbg_addr];
  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS core datapath, the next-generation replacement for the single-write, two-read register file. It provides NUM_RD combinational read ports, two prioritised write ports (ALU writeback and load/mult writeback), optional write-to-read bypass, optional hardwired-zero register 0, an asynchronous clear, and a per-register pending-write scoreboard for hazard detection in a pipelined core.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0, writes and allocs to it are ignored
- BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to read ports
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational from rd_addr
- rd_busy  out  NUM_RD  scoreboard busy bit for each read address
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load/mult writeback; higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- alloc_en  in  1  mark alloc_addr as having an outstanding producer
- alloc_addr  in  ADDR_W  destination register being allocated
- dbg_addr  in  ADDR_W  debug tap address
- dbg_data  out  DATA_W  debug tap data (stored value, never bypassed)
- busy_vec  out  2**ADDR_W  full scoreboard, bit n = register n busy

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits.
- Write: on rising clk, if we0, reg[wa0] <= wd0; if we1, reg[wa1] <= wd1. When both are enabled with wa0 == wa1, port 1 wins; port 0 is dropped.
- ZERO_REG=1: writes with address 0 have no effect; rd_data/dbg_data for address 0 is 0; busy bit 0 is constant 0.
- Scoreboard, per register n, at rising clk:
  - set if alloc_en and alloc_addr == n;
  - else clear if (we0 and wa0 == n) or (we1 and wa1 == n);
  - else hold.
  - Alloc has priority over a same-cycle clear, because a new producer supersedes the retiring one.
- Read, combinational:
  - BYPASS=0: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
  - BYPASS=1: if we1 and wa1 == rd_addr[i], return wd1; else if we0 and wa0 == rd_addr[i], return wd0; else the stored value. The ZERO_REG override is applied last.
  - BYPASS=1: rd_busy[i] = 0 when a write to that address is active this cycle and no same-address alloc is active; otherwise it equals the stored busy bit.
- Debug tap: dbg_data = reg[dbg_addr]. It is unaffected by BYPASS and affected by ZERO_REG.
- Reads never alter state. Any number of read ports may address the same register.

## Timing
- Reset (rst_n low, asynchronous): all registers become 0 and all busy bits become 0 immediately, without waiting for a clock edge. Consequently rd_data, dbg_data, rd_busy and busy_vec are all 0 during reset.
- While rst_n is low, writes and allocs are ignored. Deassertion is released synchronously by the surrounding reset synchroniser, and the first update occurs on the first rising edge with rst_n high.
- Reset during an in-flight write: the write is lost and the register stays 0.
- Write latency: 1 cycle to storage. With BYPASS=1 there are 0 cycles to the read ports. With BYPASS=0 the new value is visible on reads after the rising edge.
- Alloc latency: the busy bit is visible 1 cycle after alloc_en is sampled. The alloc does not affect the same-cycle rd_busy.
- No handshake stalls: every port is accepted every cycle.

## Test plan
- Reset clear: load reg5 = 0xDEADBEEF and alloc reg7, then pulse rst_n low mid-cycle. Required: rd_data = 0 for reg5 and busy_vec = 0 before the next edge.
- Dual-write collision: we0 = we1 = 1, wa0 = wa1 = 9, wd0 = 0x11111111, wd1 = 0x22222222. Required: after the edge, reg9 reads 0x22222222. Also write wa0 = 3 and wa1 = 4 together; both land.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to reg0 via both ports and alloc reg0. Required: reg0 reads 0, busy_vec[0] = 0, and dbg_data at 0 is 0.
- Bypass: with BYPASS=1, rd_addr[0] = 12 and we0 with wa0 = 12, wd0 = 0xCAFEF00D. Required: rd_data[0] = 0xCAFEF00D in the same cycle. With BYPASS=0, the old value is returned that cycle and the new value the next.
- Scoreboard: alloc reg10 in cycle 0, then busy[10] = 1 in cycle 1. Write reg10 and alloc reg10 in the same cycle; busy[10] stays 1. Write reg10 alone; busy[10] = 0 next cycle, and rd_busy = 0 in the write cycle when BYPASS=1.
- Port count: with NUM_RD = 4, drive four distinct addresses plus one duplicate. Required: each port independently returns its stored value against the reference model over 10k random write/alloc/read cycles.
